// File: rtl/reg_file_wr_arbiter_if.sv
// Write-port bus between the two requesters, the arbiter, and the register file.
// master = requester/register-file side, slave = arbiter.
interface reg_file_wr_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) ();
    logic                  req0_valid;
    logic [ADDR_WIDTH-1:0] req0_reg;
    logic [DATA_WIDTH-1:0] req0_data;
    logic                  req0_ready;
    logic                  req1_valid;
    logic [ADDR_WIDTH-1:0] req1_reg;
    logic [DATA_WIDTH-1:0] req1_data;
    logic                  req1_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_reg;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  busy;

    modport master (
        output req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
        input  req0_ready, req1_ready, wr_en, wr_reg, wr_data, busy
    );

    modport slave (
        input  req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
        output req0_ready, req1_ready, wr_en, wr_reg, wr_data, busy
    );
endinterface

// File: rtl/reg_file_wr_arbiter.sv
// Round-robin arbiter for the register file's single write port, with a
// post-reset sweep that zeroes x1..x(2**ADDR_WIDTH-1).
module reg_file_wr_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input logic                clk,
    input logic                rst,
    reg_file_wr_arbiter_if.slave bus
);
    typedef enum logic {CLEAR, RUN} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_REG  = '1;
    localparam logic [ADDR_WIDTH-1:0] FIRST_REG = ADDR_WIDTH'(1);

    state_t                          state_q, state_d;
    logic [ADDR_WIDTH-1:0]           clr_cnt;
    logic                            last_grant;
    logic                            wr_en_q;
    logic [ADDR_WIDTH-1:0]           wr_reg_q;
    logic [DATA_WIDTH-1:0]           wr_data_q;

    logic [1:0]                      valid, ready;
    logic [1:0][ADDR_WIDTH-1:0]      req_reg;
    logic [1:0][DATA_WIDTH-1:0]      req_data;
    logic                            gnt;

    assign valid    = {bus.req1_valid, bus.req0_valid};
    assign req_reg  = {bus.req1_reg,   bus.req0_reg};
    assign req_data = {bus.req1_data,  bus.req0_data};

    always_comb begin
        state_d = state_q;
        ready   = 2'b00;
        if (state_q == CLEAR) begin
            if (clr_cnt == LAST_REG) state_d = RUN;
        end else if (&valid) begin
            // conflict: the requester not served last wins
            ready[~last_grant] = 1'b1;
        end else begin
            ready = valid;
        end
    end

    // ready is one-hot or zero, so bit 1 alone names the winner
    assign gnt = ready[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= CLEAR_ON_RESET ? CLEAR : RUN;
            clr_cnt    <= FIRST_REG;
            last_grant <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_reg_q   <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR) begin
                wr_en_q   <= 1'b1;
                wr_reg_q  <= clr_cnt;
                wr_data_q <= '0;
                if (clr_cnt != LAST_REG) clr_cnt <= clr_cnt + 1'b1;
            end else if (|ready) begin
                // x0 writes are accepted but never reach the file
                wr_en_q    <= (req_reg[gnt] != '0);
                wr_reg_q   <= req_reg[gnt];
                wr_data_q  <= req_data[gnt];
                last_grant <= gnt;
            end else begin
                wr_en_q <= 1'b0;
            end
        end
    end

    assign bus.req0_ready = ready[0];
    assign bus.req1_ready = ready[1];
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_reg     = wr_reg_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = (state_q == CLEAR);
endmodule
